// File: rtl/cass_in_decoder.sv
// Laser 310 cassette-input decoder: sync + glitch filter, period measurement, bit pairing, byte framing.
// Optional running checksum output when CASS_DEC_CHKSUM_EN is defined.
//
//   state | meaning
//   HUNT  | shifting bits, comparing each new 8-bit window against SYNC_BYTE
//   DATA  | locked to byte boundary, emitting one byte per 8 bits
module cass_in_decoder #(
    parameter int unsigned FILT_LEN   = 8,
    parameter int unsigned PERIOD_MIN = 500,
    parameter int unsigned SHORT_MAX  = 7000,
    parameter int unsigned LONG_MAX   = 16000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hFE
) (
    input  logic        iCLK_18_4,
    input  logic        iRST,
    input  logic        iCASS_IN,
    input  logic        iENABLE,
    output logic [7:0]  oBYTE,
    output logic        oBYTE_VALID,
    output logic        oSYNC,
    output logic        oGAP,
    output logic        oERR,
    output logic        oLOCKED
`ifdef CASS_DEC_CHKSUM_EN
    ,
    output logic [15:0] oCHKSUM
`endif
);

    localparam logic [7:0]  FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [15:0] PER_MIN   = 16'(PERIOD_MIN);
    localparam logic [15:0] SHORT_LIM = 16'(SHORT_MAX);
    localparam logic [15:0] LONG_LIM  = 16'(LONG_MAX);
    localparam logic [15:0] GAP_LIM   = 16'(LONG_MAX + 1);

    typedef enum logic {HUNT, DATA} decState_t;

    logic        syncA;
    logic        syncB;
    logic        filtLvl;
    logic [7:0]  filtCnt;
    logic        risePulse;

    logic [15:0] periodCnt;
    logic        armed;
    logic        clsValid;
    logic        clsLong;
    logic        gapHit;

    decState_t   state;
    logic        phase;
    logic [6:0]  bitHist;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftNext;

    // Completed 8-bit window including the bit being decoded this cycle; short+short is a 1.
    assign shiftNext = {bitHist, ~clsLong};

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            syncA     <= 1'b0;
            syncB     <= 1'b0;
            filtLvl   <= 1'b0;
            filtCnt   <= 8'd0;
            risePulse <= 1'b0;
        end else begin
            syncA     <= iCASS_IN;
            syncB     <= syncA;
            risePulse <= 1'b0;
            if (syncB != filtLvl) begin
                if (filtCnt == FILT_LAST) begin
                    filtLvl   <= ~filtLvl;
                    filtCnt   <= 8'd0;
                    risePulse <= ~filtLvl;
                end else begin
                    filtCnt <= filtCnt + 8'd1;
                end
            end else begin
                filtCnt <= 8'd0;
            end
        end
    end

    // Edge processing wins over the gap check; a cleared counter then restarts the gap timer.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            periodCnt <= 16'd0;
            armed     <= 1'b0;
            clsValid  <= 1'b0;
            clsLong   <= 1'b0;
            gapHit    <= 1'b0;
        end else begin
            clsValid <= 1'b0;
            gapHit   <= 1'b0;
            if (periodCnt != 16'hFFFF) begin
                periodCnt <= periodCnt + 16'd1;
            end
            if (!iENABLE) begin
                armed <= 1'b0;
            end else if (risePulse) begin
                if (!armed) begin
                    armed     <= 1'b1;
                    periodCnt <= 16'd0;
                end else if (periodCnt >= PER_MIN) begin
                    periodCnt <= 16'd0;
                    if (periodCnt <= LONG_LIM) begin
                        clsValid <= 1'b1;
                        clsLong  <= (periodCnt >= SHORT_LIM);
                    end
                end
            end else if (armed && (periodCnt == GAP_LIM)) begin
                gapHit <= 1'b1;
                armed  <= 1'b0;
            end
        end
    end

`ifdef CASS_DEC_CHKSUM_EN
    logic [15:0] chkSum;
    assign oCHKSUM = chkSum;
`endif

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state       <= HUNT;
            phase       <= 1'b0;
            bitHist     <= 7'd0;
            bitCnt      <= 3'd0;
            oBYTE       <= 8'd0;
            oBYTE_VALID <= 1'b0;
            oSYNC       <= 1'b0;
            oGAP        <= 1'b0;
            oERR        <= 1'b0;
            oLOCKED     <= 1'b0;
`ifdef CASS_DEC_CHKSUM_EN
            chkSum      <= 16'd0;
`endif
        end else begin
            oBYTE_VALID <= 1'b0;
            oSYNC       <= 1'b0;
            oGAP        <= 1'b0;
            oERR        <= 1'b0;
            if (!iENABLE) begin
                state   <= HUNT;
                phase   <= 1'b0;
                bitCnt  <= 3'd0;
                oLOCKED <= 1'b0;
            end else if (gapHit) begin
                oGAP    <= 1'b1;
                state   <= HUNT;
                phase   <= 1'b0;
                bitCnt  <= 3'd0;
                oLOCKED <= 1'b0;
            end else if (clsValid) begin
                if (!phase) begin
                    // A long cycle cannot open a bit pair; stay in phase 0 to resync.
                    if (clsLong) begin
                        oERR <= 1'b1;
                    end else begin
                        phase <= 1'b1;
                    end
                end else begin
                    phase   <= 1'b0;
                    bitHist <= shiftNext[6:0];
                    case (state)
                        HUNT: begin
                            if (shiftNext == SYNC_BYTE) begin
                                oSYNC   <= 1'b1;
                                state   <= DATA;
                                bitCnt  <= 3'd0;
                                oLOCKED <= 1'b1;
`ifdef CASS_DEC_CHKSUM_EN
                                chkSum  <= 16'd0;
`endif
                            end
                        end
                        DATA: begin
                            bitCnt <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                oBYTE       <= shiftNext;
                                oBYTE_VALID <= 1'b1;
`ifdef CASS_DEC_CHKSUM_EN
                                chkSum      <= chkSum + {8'd0, shiftNext};
`endif
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cass_in_decoder.sv
// Self-checking bench for cass_in_decoder; timing parameters are scaled down to keep runs short.
// Expected bytes are queued as stimulus is driven and compared as oBYTE_VALID strobes arrive.
module tb_cass_in_decoder;

    localparam int CLK_P     = 54;
    localparam int FILT_LEN  = 8;
    localparam int PER_MIN   = 40;
    localparam int SHORT_MAX = 350;
    localparam int LONG_MAX  = 800;
    localparam int SHORT_P   = 200;
    localparam int LONG_P    = 600;
    localparam int IDLE_P    = LONG_MAX + 300;

    logic        clk = 1'b0;
    logic        iRST = 1'b1;
    logic        iCASS_IN = 1'b0;
    logic        iENABLE = 1'b1;
    logic [7:0]  oBYTE;
    logic        oBYTE_VALID;
    logic        oSYNC;
    logic        oGAP;
    logic        oERR;
    logic        oLOCKED;
`ifdef CASS_DEC_CHKSUM_EN
    logic [15:0] oCHKSUM;
`endif

    always #(CLK_P / 2) clk = ~clk;

    cass_in_decoder #(
        .FILT_LEN  (FILT_LEN),
        .PERIOD_MIN(PER_MIN),
        .SHORT_MAX (SHORT_MAX),
        .LONG_MAX  (LONG_MAX),
        .SYNC_BYTE (8'hFE)
    ) dut (
        .iCLK_18_4  (clk),
        .iRST       (iRST),
        .iCASS_IN   (iCASS_IN),
        .iENABLE    (iENABLE),
        .oBYTE      (oBYTE),
        .oBYTE_VALID(oBYTE_VALID),
        .oSYNC      (oSYNC),
        .oGAP       (oGAP),
        .oERR       (oERR),
`ifdef CASS_DEC_CHKSUM_EN
        .oLOCKED    (oLOCKED),
        .oCHKSUM    (oCHKSUM)
`else
        .oLOCKED    (oLOCKED)
`endif
    );

    int         nCompared = 0;
    int         nMismatched = 0;
    logic [7:0] expByteQ[$];
    logic [7:0] popB;
    int         syncCnt = 0, gapCnt = 0, errCnt = 0, riseCnt = 0, byteCnt = 0;
    time        lastValidTime = 0, lastGapTime = 0, tClose = 0;

    always @(negedge clk) begin
        if (dut.risePulse) riseCnt++;
        if (oSYNC) syncCnt++;
        if (oERR) errCnt++;
        if (oGAP) begin
            gapCnt++;
            lastGapTime = $time;
        end
        if (oBYTE_VALID) begin
            byteCnt++;
            lastValidTime = $time;
            nCompared++;
            if (expByteQ.size() == 0) begin
                nMismatched++;
                $display("FAIL byte_unexpected: got %02h, required no byte", oBYTE);
            end else begin
                popB = expByteQ.pop_front();
                if (oBYTE !== popB) begin
                    nMismatched++;
                    $display("FAIL byte_value: got %02h, required %02h", oBYTE, popB);
                end
            end
        end
    end

    task automatic clkN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cyc(input int p);
        iCASS_IN = 1'b1;
        clkN(p / 2);
        iCASS_IN = 1'b0;
        clkN(p - p / 2);
    endtask

    task automatic sendBit(input logic b);
        cyc(SHORT_P);
        cyc(b ? SHORT_P : LONG_P);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    // Final rising edge that terminates the last measured cycle.
    task automatic closeEdge();
        iCASS_IN = 1'b1;
        tClose = $time;
        clkN(100);
        iCASS_IN = 0;
        clkN(40);
    endtask

    task automatic checkQuiet(input string tag);
        nCompared++;
        if (oBYTE !== 8'd0 || oBYTE_VALID !== 1'b0 || oSYNC !== 1'b0 || oGAP !== 1'b0 ||
            oERR !== 1'b0 || oLOCKED !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s_outputs: got byte=%02h v=%b s=%b g=%b e=%b l=%b, required all 0",
                     tag, oBYTE, oBYTE_VALID, oSYNC, oGAP, oERR, oLOCKED);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        clkN(3);
        checkQuiet("reset");
`ifdef CASS_DEC_CHKSUM_EN
        nCompared++;
        if (oCHKSUM !== 16'd0) begin
            nMismatched++;
            $display("FAIL reset_chksum: got %04h, required 0000", oCHKSUM);
        end
`endif
        iRST = 1'b0;
        clkN(5);
    endtask

    task automatic test_glitch();
        int r0;
        r0 = riseCnt;
        iCASS_IN = 1'b1;
        clkN(FILT_LEN - 1);
        iCASS_IN = 1'b0;
        clkN(30);
        nCompared++;
        if (riseCnt - r0 !== 0) begin
            nMismatched++;
            $display("FAIL glitch_short: got %0d edges, required 0", riseCnt - r0);
        end
        iCASS_IN = 1'b1;
        clkN(FILT_LEN + 1);
        iCASS_IN = 1'b0;
        clkN(30);
        nCompared++;
        if (riseCnt - r0 !== 1) begin
            nMismatched++;
            $display("FAIL glitch_long: got %0d edges, required 1", riseCnt - r0);
        end
        clkN(IDLE_P);
    endtask

    task automatic test_sync_data();
        int s0, e0;
        logic [15:0] expSum;
        s0 = syncCnt;
        e0 = errCnt;
        expByteQ.push_back(8'h41);
        expByteQ.push_back(8'hA5);
        expSum = 16'h0041 + 16'h00A5;
        sendByte(8'h80);
        sendByte(8'hFE);
        sendByte(8'h41);
        sendByte(8'hA5);
        closeEdge();
        nCompared++;
        if (syncCnt - s0 !== 1) begin
            nMismatched++;
            $display("FAIL sync_count: got %0d, required 1", syncCnt - s0);
        end
        nCompared++;
        if (expByteQ.size() !== 0) begin
            nMismatched++;
            $display("FAIL sync_bytes_missing: got %0d left, required 0", expByteQ.size());
        end
        nCompared++;
        if (errCnt - e0 !== 0) begin
            nMismatched++;
            $display("FAIL sync_err: got %0d, required 0", errCnt - e0);
        end
        nCompared++;
        if (oLOCKED !== 1'b1) begin
            nMismatched++;
            $display("FAIL sync_locked: got %b, required 1", oLOCKED);
        end
        nCompared++;
        if (lastValidTime - tClose !== time'(12 * CLK_P)) begin
            nMismatched++;
            $display("FAIL byte_latency: got %0t, required %0d", lastValidTime - tClose, 12 * CLK_P);
        end
`ifdef CASS_DEC_CHKSUM_EN
        nCompared++;
        if (oCHKSUM !== expSum) begin
            nMismatched++;
            $display("FAIL chksum: got %04h, required %04h", oCHKSUM, expSum);
        end
`else
        if (expSum == 16'd0) $display("note: zero checksum");
`endif
    endtask

    task automatic test_gap();
        int g0, dly;
        g0 = gapCnt;
        clkN(LONG_MAX + 200);
        nCompared++;
        if (gapCnt - g0 !== 1) begin
            nMismatched++;
            $display("FAIL gap_count: got %0d, required 1", gapCnt - g0);
        end
        dly = int'((lastGapTime - tClose) / CLK_P);
        nCompared++;
        if (dly < LONG_MAX + 1 || dly > LONG_MAX + 20) begin
            nMismatched++;
            $display("FAIL gap_time: got %0d clocks, required %0d..%0d", dly, LONG_MAX + 1, LONG_MAX + 20);
        end
        nCompared++;
        if (oLOCKED !== 1'b0) begin
            nMismatched++;
            $display("FAIL gap_locked: got %b, required 0", oLOCKED);
        end
        clkN(2 * LONG_MAX);
        nCompared++;
        if (gapCnt - g0 !== 1) begin
            nMismatched++;
            $display("FAIL gap_repeat: got %0d, required 1", gapCnt - g0);
        end
    endtask

    task automatic test_framing();
        int e0;
        e0 = errCnt;
        expByteQ.push_back(8'hC3);
        sendByte(8'hFE);
        cyc(LONG_P);
        sendByte(8'hC3);
        closeEdge();
        nCompared++;
        if (errCnt - e0 !== 1) begin
            nMismatched++;
            $display("FAIL framing_err: got %0d, required 1", errCnt - e0);
        end
        nCompared++;
        if (expByteQ.size() !== 0) begin
            nMismatched++;
            $display("FAIL framing_byte_missing: got %0d left, required 0", expByteQ.size());
        end
        clkN(IDLE_P);
    endtask

    task automatic test_noise();
        int e0;
        e0 = errCnt;
        expByteQ.push_back(8'h5A);
        sendByte(8'hFE);
        // 20-clock noise edge inside a 220-clock short cycle, then the long half of a 0 bit.
        iCASS_IN = 1'b1;
        clkN(10);
        iCASS_IN = 1'b0;
        clkN(10);
        iCASS_IN = 1'b1;
        clkN(90);
        iCASS_IN = 1'b0;
        clkN(110);
        cyc(LONG_P);
        for (int i = 6; i >= 0; i--) sendBit(1'(8'h5A >> i));
        closeEdge();
        nCompared++;
        if (expByteQ.size() !== 0) begin
            nMismatched++;
            $display("FAIL noise_byte_missing: got %0d left, required 0", expByteQ.size());
        end
        nCompared++;
        if (errCnt - e0 !== 0) begin
            nMismatched++;
            $display("FAIL noise_err: got %0d, required 0", errCnt - e0);
        end
        clkN(IDLE_P);
    endtask

    task automatic test_enable();
        int s0, b0, g0;
        s0 = syncCnt;
        b0 = byteCnt;
        g0 = gapCnt;
        iENABLE = 1'b0;
        sendByte(8'hFE);
        sendByte(8'h41);
        closeEdge();
        clkN(IDLE_P);
        nCompared++;
        if (syncCnt - s0 !== 0 || byteCnt - b0 !== 0 || gapCnt - g0 !== 0) begin
            nMismatched++;
            $display("FAIL enable_low: got sync=%0d byte=%0d gap=%0d, required 0/0/0",
                     syncCnt - s0, byteCnt - b0, gapCnt - g0);
        end
        nCompared++;
        if (oLOCKED !== 1'b0) begin
            nMismatched++;
            $display("FAIL enable_locked: got %b, required 0", oLOCKED);
        end
        iENABLE = 1'b1;
        clkN(20);
    endtask

    task automatic test_reset_midstream();
        int s0, b0;
        s0 = syncCnt;
        b0 = byteCnt;
        sendByte(8'hFE);
        for (int i = 7; i >= 5; i--) sendBit(1'(8'h3C >> i));
        nCompared++;
        if (oLOCKED !== 1'b1) begin
            nMismatched++;
            $display("FAIL midreset_prelock: got %b, required 1", oLOCKED);
        end
        iRST = 1'b1;
        clkN(3);
        checkQuiet("midreset");
        iRST = 1'b0;
        clkN(5);
        sendByte(8'h55);
        closeEdge();
        nCompared++;
        if (byteCnt - b0 !== 0 || syncCnt - s0 !== 1) begin
            nMismatched++;
            $display("FAIL midreset_resync: got bytes=%0d syncs=%0d, required 0/1",
                     byteCnt - b0, syncCnt - s0);
        end
        nCompared++;
        if (oLOCKED !== 1'b0) begin
            nMismatched++;
            $display("FAIL midreset_locked: got %b, required 0", oLOCKED);
        end
        clkN(IDLE_P);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_sync_data();
        test_gap();
        test_framing();
        test_noise();
        test_enable();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/cass_in_decoder.md
Name: cass_in_decoder

Overview:
- Decodes the thresholded cassette-input bit from the audio codec interface (left-channel comparator output) into bytes for the Laser 310 cassette port logic.
- Synchronises and glitch-filters the input, then measures full-cycle periods between rising edges.
- Classifies each cycle as short or long and pairs cycles into bits.
- Hunts for the sync byte, then emits byte-aligned data.
- Runs in the 18.432 MHz audio clock domain.

Parameters:
- FILT_LEN, 8: consecutive stable samples required before the filtered level changes (1..255).
- PERIOD_MIN, 500: cycle periods below this many clocks are noise; the edge is ignored.
- SHORT_MAX, 7000: periods in [PERIOD_MIN, SHORT_MAX) are classified short.
- LONG_MAX, 16000: periods in [SHORT_MAX, LONG_MAX] are classified long. Longer means a gap.
- SYNC_BYTE, 8'hFE: pattern that ends the hunt.

Ports:
- iCLK_18_4 in 1: system clock, 18.432 MHz.
- iRST in 1: reset, synchronous, active-high.
- iCASS_IN in 1: raw comparator bit, asynchronous to iCLK_18_4.
- iENABLE in 1: decoder enable. When low, the decoder is held in HUNT and no output pulses are produced.
- oBYTE out 8: last decoded data byte.
- oBYTE_VALID out 1: one-clock strobe when oBYTE is updated.
- oSYNC out 1: one-clock strobe when SYNC_BYTE is matched.
- oGAP out 1: one-clock strobe on gap timeout.
- oERR out 1: one-clock strobe on framing error.
- oLOCKED out 1: high while in DATA state.

Behaviour:
- Reset (iRST high at a clock edge):
  - All outputs are 0.
  - State is HUNT, phase is 0, the shift register is 0, and the bit counter is 0.
  - The period counter is 0 and the armed flag is 0.
  - The filter level is 0 and the synchroniser flops are 0.
  - Reset mid-byte discards the partial byte; no strobe is generated.
- Input path:
  - Two-flop synchroniser feeds the glitch filter.
  - The filter counts clocks where the synchronised level differs from the filtered level. The count clears on any agreeing sample.
  - When the count reaches FILT_LEN, the filtered level toggles and the count clears.
  - Rising edge = filtered level 0->1, registered as a one-clock pulse.
- Period counter:
  - 16-bit, increments every clock and saturates at 16'hFFFF.
  - If it reaches LONG_MAX+1 while armed: oGAP pulses once; armed, phase and state return to 0/0/HUNT, bit counter clears, oLOCKED drops.
  - A gap is reported once per silence.
- On a rising edge:
  - If not armed: set armed, clear the counter, no classification.
  - If armed and period < PERIOD_MIN: the edge is ignored and the counter keeps running.
  - Otherwise the edge is classified short or long and the counter clears.
  - Gap timeout and an edge in the same clock: the edge wins, and the gap is evaluated next cycle from the cleared counter.
- Bit pairing:
  - Phase 0, short: go to phase 1.
  - Phase 0, long: oERR pulses and phase stays 0 (resync).
  - Phase 1, short: bit=1. Phase 1, long: bit=0. Either way, return to phase 0.
- Byte assembly:
  - Bits shift in at the LSB, MSB first.
  - HUNT: after every bit, compare the 8-bit shift register with SYNC_BYTE. On match: oSYNC pulses, state becomes DATA, bit counter is 0, oLOCKED=1.
  - DATA: bit counter is 3-bit and wraps 7->0. On the 8th bit: oBYTE takes the completed byte and oBYTE_VALID pulses; oSYNC is not re-checked.
- Latency: oBYTE_VALID / oSYNC / oERR assert exactly 2 clocks after the filtered rising-edge pulse that completes the event.
- iENABLE low: forces HUNT, phase 0, armed 0. The period counter still runs but gap strobes are suppressed.

Optional Feature:
- CASS_DEC_CHKSUM_EN defined:
  - Adds port oCHKSUM out 16: modulo-2^16 running sum of bytes emitted since the last oSYNC.
  - Cleared to 0 on reset and in the same cycle oSYNC pulses.
  - Updated in the same cycle as oBYTE_VALID.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Reset: drive iRST 1 for 3 clocks mid-stream -> all outputs 0 and the next byte requires a fresh sync.
- Glitch filter: 7-clock high pulse with FILT_LEN=8 -> no edge. A 9-clock high pulse -> one rising edge detected.
- Sync and data: 0x80 leader, then bit pairs for 0xFE, 0x41, 0xA5 (short=4000 clk, long=12000 clk):
  - oSYNC pulses once, then oBYTE_VALID twice with oBYTE=8'h41 then 8'hA5.
  - With CASS_DEC_CHKSUM_EN: oCHKSUM=16'h00E6.
- Gap: hold the input low for 20000 clocks after a locked byte -> one oGAP pulse at LONG_MAX+1 clocks after the last edge, oLOCKED=0, and no further oGAP.
- Framing: long cycle (12000) in phase 0 -> oERR pulses and the following short-short pair decodes bit 1.
- Noise edge: a 300-clock period inside a cycle -> ignored, and the surrounding 4000+300 period still classifies short.
